// File: rtl/branch_hazard_ctrl_if.sv
// branch_hazard_ctrl_if: ID-stage hazard inputs and front-end control outputs
interface branch_hazard_ctrl_if;
  logic        ID_Branch;
  logic        ID_Jump;
  logic        IDUsesRt;
  logic [4:0]  IDRs;
  logic [4:0]  IDRt;
  logic        IDEX_RegWrite;
  logic        IDEX_MemRead;
  logic [4:0]  IDEXRd;
  logic        EXMEM_MemRead;
  logic [4:0]  EXMEMRd;
  logic        BranchTaken;
  logic        PCWrite;
  logic        IFID_Write;
  logic        IDEX_Bubble;
  logic        IFID_Flush;
  logic        BranchGo;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;
  modport master (
    output ID_Branch, ID_Jump, IDUsesRt, IDRs, IDRt, IDEX_RegWrite, IDEX_MemRead,
           IDEXRd, EXMEM_MemRead, EXMEMRd, BranchTaken,
    input  PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, BranchGo, StallCount, FlushCount
  );
  modport slave (
    input  ID_Branch, ID_Jump, IDUsesRt, IDRs, IDRt, IDEX_RegWrite, IDEX_MemRead,
           IDEXRd, EXMEM_MemRead, EXMEMRd, BranchTaken,
    output PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, BranchGo, StallCount, FlushCount
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: stall/flush sequencer for ID-resolved branches with perf counters
module branch_hazard_ctrl (
  input logic clk,
  input logic reset,
  branch_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t      r_state;
  state_t      w_next_state;
  logic        r_rem;
  logic        w_next_rem;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_uses_rt;
  logic        w_hit_ex;
  logic        w_hit_mem;
  logic        w_n2;
  logic        w_n1;
  logic        w_in_hold;
  logic        w_stall;
  logic        w_go;
  logic        w_flush;
  assign w_uses_rt = bus.ID_Branch | bus.IDUsesRt;
  assign w_hit_ex  = (bus.IDEXRd != 5'd0) &&
                     (bus.IDEXRd == bus.IDRs || (w_uses_rt && bus.IDEXRd == bus.IDRt));
  assign w_hit_mem = (bus.EXMEMRd != 5'd0) &&
                     (bus.EXMEMRd == bus.IDRs || (w_uses_rt && bus.EXMEMRd == bus.IDRt));
  assign w_n2 = bus.ID_Branch & bus.IDEX_MemRead & w_hit_ex;
  assign w_n1 = (bus.ID_Branch & bus.IDEX_RegWrite & ~bus.IDEX_MemRead & w_hit_ex) |
                (bus.ID_Branch & bus.EXMEM_MemRead & w_hit_mem) |
                (~bus.ID_Branch & bus.IDEX_MemRead & w_hit_ex);
  assign w_in_hold = (r_state == HOLD) & r_rem;
  assign w_stall   = ~reset & (w_in_hold | w_n2 | w_n1);
  assign w_go      = ~reset & ~w_stall & bus.ID_Branch & bus.BranchTaken;
  assign w_flush   = ~reset & ~w_stall & (w_go | bus.ID_Jump);
  assign bus.PCWrite     = ~w_stall;
  assign bus.IFID_Write  = ~w_stall;
  assign bus.IDEX_Bubble = w_stall;
  assign bus.BranchGo    = w_go;
  assign bus.IFID_Flush  = w_flush;
  assign bus.StallCount  = r_stall_cnt;
  assign bus.FlushCount  = r_flush_cnt;
  // next state: a two-cycle hazard parks in HOLD for one extra stall, HOLD always drains to RUN
  always_comb begin
    w_next_state = RUN;
    w_next_rem   = 1'b0;
    if (!w_in_hold && w_n2) begin
      w_next_state = HOLD;
      w_next_rem   = 1'b1;
    end
  end
  // state register and saturating stall/flush counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_rem       <= 1'b0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed checks of stall/flush sequencing and counters
module tb_branch_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  branch_hazard_ctrl_if bus ();
  branch_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [4:0] ctl;
  assign ctl = {bus.PCWrite, bus.IFID_Write, bus.IDEX_Bubble, bus.BranchGo, bus.IFID_Flush};
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] ISSUE = 5'b11000;
  localparam logic [4:0] TAKEN = 5'b11011;
  localparam logic [4:0] JUMP  = 5'b11001;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.ID_Branch = 0; bus.ID_Jump = 0; bus.IDUsesRt = 0;
    bus.IDRs = 0; bus.IDRt = 0;
    bus.IDEX_RegWrite = 0; bus.IDEX_MemRead = 0; bus.IDEXRd = 0;
    bus.EXMEM_MemRead = 0; bus.EXMEMRd = 0; bus.BranchTaken = 0;
  endtask
  task automatic load_branch();
    idle();
    bus.ID_Branch = 1; bus.IDRs = 8; bus.BranchTaken = 1;
    bus.IDEX_MemRead = 1; bus.IDEX_RegWrite = 1; bus.IDEXRd = 8;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    load_branch();
    tick();
    @(negedge clk);
    chk("reset_ctl", {11'd0, ctl}, {11'd0, ISSUE});
    tick();
    reset = 0;
    chk("reset_stall_cnt", bus.StallCount, 16'd0);
    chk("reset_flush_cnt", bus.FlushCount, 16'd0);
    load_branch();
    @(negedge clk);
    chk("lb_stall1", {11'd0, ctl}, {11'd0, STALL});
    tick();
    @(negedge clk);
    chk("lb_stall2", {11'd0, ctl}, {11'd0, STALL});
    tick();
    bus.IDEX_MemRead = 0; bus.IDEX_RegWrite = 0; bus.IDEXRd = 0;
    @(negedge clk);
    chk("lb_taken", {11'd0, ctl}, {11'd0, TAKEN});
    tick();
    chk("lb_stall_cnt", bus.StallCount, 16'd2);
    chk("lb_flush_cnt", bus.FlushCount, 16'd1);
    idle();
    bus.ID_Branch = 1; bus.IDRt = 9; bus.IDEX_RegWrite = 1; bus.IDEXRd = 9;
    @(negedge clk);
    chk("alu_stall", {11'd0, ctl}, {11'd0, STALL});
    tick();
    bus.IDEX_RegWrite = 0; bus.IDEXRd = 0; bus.EXMEMRd = 9;
    @(negedge clk);
    chk("alu_issue", {11'd0, ctl}, {11'd0, ISSUE});
    tick();
    chk("alu_stall_cnt", bus.StallCount, 16'd3);
    idle();
    bus.ID_Branch = 1; bus.IDEX_MemRead = 1; bus.IDEX_RegWrite = 1; bus.BranchTaken = 1;
    @(negedge clk);
    chk("r0_taken", {11'd0, ctl}, {11'd0, TAKEN});
    bus.BranchTaken = 0;
    #1;
    chk("r0_not_taken", {11'd0, ctl}, {11'd0, ISSUE});
    bus.BranchTaken = 1;
    tick();
    chk("r0_flush_cnt", bus.FlushCount, 16'd2);
    chk("r0_stall_cnt", bus.StallCount, 16'd3);
    idle();
    bus.IDEX_MemRead = 1; bus.IDEX_RegWrite = 1; bus.IDEXRd = 5; bus.IDRt = 5; bus.IDRs = 1;
    @(negedge clk);
    chk("nb_no_rt", {11'd0, ctl}, {11'd0, ISSUE});
    bus.IDUsesRt = 1;
    #1;
    chk("nb_uses_rt", {11'd0, ctl}, {11'd0, STALL});
    tick();
    chk("nb_stall_cnt", bus.StallCount, 16'd4);
    idle();
    bus.ID_Jump = 1;
    @(negedge clk);
    chk("jump", {11'd0, ctl}, {11'd0, JUMP});
    tick();
    chk("jump_flush_cnt", bus.FlushCount, 16'd3);
    idle();
    bus.ID_Branch = 1; bus.IDRs = 7; bus.EXMEM_MemRead = 1; bus.EXMEMRd = 7; bus.BranchTaken = 1;
    @(negedge clk);
    chk("mem_load_stall", {11'd0, ctl}, {11'd0, STALL});
    tick();
    bus.EXMEM_MemRead = 0; bus.EXMEMRd = 0;
    @(negedge clk);
    chk("mem_load_go", {11'd0, ctl}, {11'd0, TAKEN});
    tick();
    chk("mem_stall_cnt", bus.StallCount, 16'd5);
    chk("mem_flush_cnt", bus.FlushCount, 16'd4);
    load_branch();
    @(negedge clk);
    chk("rh_stall1", {11'd0, ctl}, {11'd0, STALL});
    tick();
    reset = 1;
    @(negedge clk);
    chk("rh_reset_ctl", {11'd0, ctl}, {11'd0, ISSUE});
    tick();
    reset = 0;
    idle();
    @(negedge clk);
    chk("rh_run_ctl", {11'd0, ctl}, {11'd0, ISSUE});
    chk("rh_stall_cnt", bus.StallCount, 16'd0);
    chk("rh_flush_cnt", bus.FlushCount, 16'd0);
    tick();
    bus.IDEX_MemRead = 1; bus.IDEXRd = 5; bus.IDRs = 5;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", bus.StallCount, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_ffff", bus.StallCount, 16'hFFFF);
    end
    @(negedge clk);
    chk("sat_still_stall", {11'd0, ctl}, {11'd0, STALL});
    chk("sat_flush_cnt", bus.FlushCount, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
